// File: rtl/homing_sequencer.sv
// ----------------------------------------------------------------------------
// homing_sequencer
//
// Per-axis homing controller. While homing, it takes over the velocity and
// acceleration setpoints of one motion channel and runs the channel through
// this sequence: fast seek toward the endstop, stop, back off until the
// endstop has been released for BACKOFF_STEPS steps, stop, slow re-approach,
// stop, then pulse zero_pos so that the channel clears its position.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   i_start     one-cycle pulse; begins homing (ignored while busy or with abort)
//   i_abort     one-cycle pulse; cancels homing (ignored while idle)
//   i_endstop   debounced endstop, 1 = triggered
//   i_step      one-cycle pulse per motor step issued by the channel
//   i_v_zero    1 when the channel's actual velocity is 0
//   o_v_target  signed two's-complement velocity setpoint
//   o_accel     acceleration magnitude
//   o_override  1 = the channel takes o_v_target/o_accel from this block
//   o_zero_pos  one-cycle pulse; clear the channel position
//   o_busy      homing in progress
//   o_done      homing finished successfully (held until the next start)
//   o_error     homing failed or was aborted (held until the next start)
//
// Optional feature
//   HOMING_TIMEOUT_EN : when defined, a per-phase watchdog sends the sequence
//   to ERR if any busy phase (other than ERR/ABORTING) lasts TIMEOUT cycles.
//   When undefined there is no timer, and a phase waits indefinitely.
// ----------------------------------------------------------------------------
module homing_sequencer #(
    parameter logic [31:0] FAST_V        = 32'd400000,
    parameter logic [31:0] SLOW_V        = 32'd40000,
    parameter logic [31:0] ACCEL         = 32'd5,
    parameter logic [31:0] ABORT_ACCEL   = 32'd10,
    parameter logic [15:0] BACKOFF_STEPS = 16'd200,
    parameter logic        DIR           = 1'b0
`ifdef HOMING_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT       = 32'd50000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_endstop,
    input  logic        i_step,
    input  logic        i_v_zero,
    output logic [31:0] o_v_target,
    output logic [31:0] o_accel,
    output logic        o_override,
    output logic        o_zero_pos,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FAST_SEEK,
        S_STOP1,
        S_BACKOFF,
        S_STOP2,
        S_SLOW_SEEK,
        S_STOP3,
        S_ZERO,
        S_FIN,
        S_ERR,
        S_ABORTING
    } state_t;

    // Signed setpoints. Seeks move toward the endstop (sign S), the back-off
    // moves away from it (sign -S).
    localparam logic [31:0] V_FAST_SEEK = DIR ? FAST_V : (~FAST_V + 32'd1);
    localparam logic [31:0] V_SLOW_SEEK = DIR ? SLOW_V : (~SLOW_V + 32'd1);
    localparam logic [31:0] V_BACKOFF   = DIR ? (~SLOW_V + 32'd1) : SLOW_V;

    // Back-off gives up once more than four times the release distance has
    // been stepped without a clean release.
    localparam logic [17:0] BACKOFF_LIMIT = {BACKOFF_STEPS, 2'b00};

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_step_cnt;
    logic [17:0] r_total_cnt;
    logic        r_done;
    logic        r_error;

    logic [31:0] w_v_target;
    logic [31:0] w_accel;
    logic        w_override;
    logic        w_zero_pos;
    logic        w_busy;
    logic        w_start_ok;
    logic        w_set_done;
    logic        w_set_error;
    logic        w_enter_backoff;
    logic        w_timeout;
    logic        w_timed_state;

    // States in which the watchdog may run: every busy state except the two
    // stop-and-fail states, which must be allowed to wait for v_zero.
    assign w_timed_state = (r_state != S_IDLE) && (r_state != S_FIN) &&
                           (r_state != S_ERR)  && (r_state != S_ABORTING);

`ifdef HOMING_TIMEOUT_EN
    logic [31:0] r_phase_timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_timer <= '0;
        end else if (w_state_next != r_state) begin
            r_phase_timer <= '0;
        end else if (w_timed_state) begin
            r_phase_timer <= r_phase_timer + 32'd1;
        end
    end

    // Timer holds the number of completed cycles in this phase, so the
    // TIMEOUT-th cycle is the one that sees TIMEOUT-1.
    assign w_timeout = w_timed_state && (r_phase_timer >= (TIMEOUT - 32'd1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples the pre-edge values of its inputs.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // skipped one would infer a latch.
        w_state_next = r_state;
        w_v_target   = '0;
        w_accel      = '0;
        w_override   = 1'b0;
        w_zero_pos   = 1'b0;
        w_busy       = 1'b0;
        w_start_ok   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort arriving with start cancels the start
                if (i_start && !i_abort) begin
                    w_start_ok   = 1'b1;
                    w_state_next = i_endstop ? S_STOP1 : S_FAST_SEEK;
                end
            end

            S_FAST_SEEK: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_v_target = V_FAST_SEEK;
                w_accel    = ACCEL;
                if (i_endstop) begin
                    w_state_next = S_STOP1;
                end
            end

            S_STOP1: begin
                // endstop is deliberately not looked at: a release while
                // decelerating does not shorten the stop
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_accel    = ABORT_ACCEL;
                if (i_v_zero) begin
                    w_state_next = S_BACKOFF;
                end
            end

            S_BACKOFF: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_v_target = V_BACKOFF;
                w_accel    = ACCEL;
                if (!i_endstop && (r_step_cnt >= BACKOFF_STEPS)) begin
                    w_state_next = S_STOP2;
                end else if (r_total_cnt > BACKOFF_LIMIT) begin
                    w_state_next = S_ERR;
                end
            end

            S_STOP2: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_accel    = ACCEL;
                if (i_v_zero) begin
                    w_state_next = S_SLOW_SEEK;
                end
            end

            S_SLOW_SEEK: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_v_target = V_SLOW_SEEK;
                w_accel    = ACCEL;
                if (i_endstop) begin
                    w_state_next = S_STOP3;
                end
            end

            S_STOP3: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_accel    = ABORT_ACCEL;
                if (i_v_zero) begin
                    w_state_next = S_ZERO;
                end
            end

            S_ZERO: begin
                // channel is already stationary; keep the stop settings while
                // the position is cleared
                w_busy       = 1'b1;
                w_override   = 1'b1;
                w_accel      = ABORT_ACCEL;
                w_zero_pos   = 1'b1;
                w_state_next = S_FIN;
            end

            S_FIN: begin
                w_state_next = S_IDLE;
            end

            S_ERR, S_ABORTING: begin
                w_busy     = 1'b1;
                w_override = 1'b1;
                w_accel    = ABORT_ACCEL;
                if (i_v_zero) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort beats every other transition; the watchdog beats the phase's
        // own exit condition.
        if (w_busy && i_abort) begin
            w_state_next = S_ABORTING;
        end else if (w_timeout) begin
            w_state_next = S_ERR;
        end
    end

    // Flag updates are derived from the final next state so that an abort
    // overriding a phase exit never raises done or error by mistake.
    assign w_set_done      = (w_state_next == S_FIN);
    assign w_set_error     = ((r_state == S_ERR) || (r_state == S_ABORTING)) &&
                             (w_state_next == S_IDLE);
    assign w_enter_backoff = (r_state != S_BACKOFF) && (w_state_next == S_BACKOFF);

    // ------------------------------------------------------------------
    // Back-off step counters
    //   r_step_cnt  : steps since the endstop last released (held at 0 while
    //                 the endstop is triggered), saturating
    //   r_total_cnt : every step in this back-off phase, saturating
    // Clearing on entry means a step in the entry cycle is never counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_enter_backoff) begin
            r_step_cnt  <= '0;
            r_total_cnt <= '0;
        end else if (r_state == S_BACKOFF) begin
            if (i_endstop) begin
                r_step_cnt <= '0;
            end else if (i_step && (r_step_cnt != 16'hFFFF)) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
            if (i_step && (r_total_cnt != 18'h3FFFF)) begin
                r_total_cnt <= r_total_cnt + 18'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky completion flags, cleared only by an accepted start
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_v_target = w_v_target;
    assign o_accel    = w_accel;
    assign o_override = w_override;
    assign o_zero_pos = w_zero_pos;
    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_error    = r_error;

endmodule

// File: tb/tb_homing_sequencer.sv
// ----------------------------------------------------------------------------
// tb_homing_sequencer
//
// Directed bench for homing_sequencer with default parameters (DIR = 0).
// A table of {cycles, inputs, expected outputs} records is replayed one clock
// at a time; every record is checked on every cycle it covers. Hand-written
// sequences then cover the long idle seek and a closed-loop homing run
// against a simple position/endstop model.
// ----------------------------------------------------------------------------
module tb_homing_sequencer;

    // Expected setpoints for DIR = 0 (S = -1)
    localparam logic [31:0] V_FAST = 32'hFFF9_E580;  // -400000
    localparam logic [31:0] V_SLOW = 32'hFFFF_63C0;  // -40000
    localparam logic [31:0] V_BACK = 32'h0000_9C40;  // +40000

    // Input bits {rst, start, abort, endstop, step, v_zero}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_RST   = 6'b100000;
    localparam logic [5:0] I_START = 6'b010000;
    localparam logic [5:0] I_ABORT = 6'b001000;
    localparam logic [5:0] I_ES    = 6'b000100;
    localparam logic [5:0] I_STEP  = 6'b000010;
    localparam logic [5:0] I_VZ    = 6'b000001;

    // Flag bits {override, zero_pos, busy, done, error}
    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_RUN  = 5'b10100;
    localparam logic [4:0] F_ZERO = 5'b11100;
    localparam logic [4:0] F_DONE = 5'b00010;
    localparam logic [4:0] F_ERR  = 5'b00001;

    typedef struct {
        int          n;
        logic [5:0]  in;
        logic [31:0] vt;
        logic [31:0] acc;
        logic [4:0]  fl;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic        i_endstop;
    logic        i_step;
    logic        i_v_zero;
    logic [31:0] o_v_target;
    logic [31:0] o_accel;
    logic        o_override;
    logic        o_zero_pos;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int   n_compared;
    int   n_mismatched;
    vec_t vecs[$];

    homing_sequencer #(
        .FAST_V       (32'd400000),
        .SLOW_V       (32'd40000),
        .ACCEL        (32'd5),
        .ABORT_ACCEL  (32'd10),
        .BACKOFF_STEPS(16'd200),
        .DIR          (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_endstop (i_endstop),
        .i_step    (i_step),
        .i_v_zero  (i_v_zero),
        .o_v_target(o_v_target),
        .o_accel   (o_accel),
        .o_override(o_override),
        .o_zero_pos(o_zero_pos),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic add(input int n, input logic [5:0] in, input logic [31:0] vt,
                       input logic [31:0] acc, input logic [4:0] fl);
        vec_t v;
        v.n   = n;
        v.in  = in;
        v.vt  = vt;
        v.acc = acc;
        v.fl  = fl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] in);
        {rst, i_start, i_abort, i_endstop, i_step, i_v_zero} = in;
    endtask

    function automatic logic [68:0] outs();
        return {o_v_target, o_accel, o_override, o_zero_pos, o_busy, o_done, o_error};
    endfunction

    initial begin
        int pos;
        int zp_count;
        bit finished;

        n_compared   = 0;
        n_mismatched = 0;
        drive(I_RST);

        // ---- main sequence, DIR = 0, endstop initially open ----
        add(2,   I_RST,                   32'd0, 32'd0,  F_IDLE);
        add(2,   I_NONE,                  32'd0, 32'd0,  F_IDLE);
        add(1,   I_START,                 V_FAST, 32'd5,  F_RUN);   // FAST_SEEK after 1 cycle
        add(999, I_NONE,                  V_FAST, 32'd5,  F_RUN);
        add(1,   I_ES,                    32'd0, 32'd10, F_RUN);    // STOP1
        add(4,   I_ES,                    32'd0, 32'd10, F_RUN);
        add(3,   I_NONE,                  32'd0, 32'd10, F_RUN);    // release ignored in STOP1
        add(1,   I_ES | I_VZ | I_STEP,    V_BACK, 32'd5,  F_RUN);   // BACKOFF; entry step not counted
        add(10,  I_ES | I_STEP,           V_BACK, 32'd5,  F_RUN);   // counter held at 0
        add(199, I_STEP,                  V_BACK, 32'd5,  F_RUN);   // 199 counted
        add(1,   I_STEP | I_START,        V_BACK, 32'd5,  F_RUN);   // 200th, start ignored
        add(1,   I_NONE,                  32'd0, 32'd5,  F_RUN);    // STOP2
        add(2,   I_START,                 32'd0, 32'd5,  F_RUN);
        add(1,   I_VZ,                    V_SLOW, 32'd5,  F_RUN);   // SLOW_SEEK
        add(20,  I_NONE,                  V_SLOW, 32'd5,  F_RUN);
        add(1,   I_ES,                    32'd0, 32'd10, F_RUN);    // STOP3
        add(2,   I_NONE,                  32'd0, 32'd10, F_RUN);    // release ignored in STOP3
        add(1,   I_VZ,                    32'd0, 32'd10, F_ZERO);   // ZERO, single pulse
        add(1,   I_VZ,                    32'd0, 32'd0,  F_DONE);   // FIN
        add(3,   I_NONE,                  32'd0, 32'd0,  F_DONE);   // done held in IDLE

        // ---- endstop already closed at start, then stuck during back-off ----
        add(1,   I_START | I_ES,          32'd0, 32'd10, F_RUN);    // STOP1 directly, done cleared
        add(1,   I_ES | I_VZ,             V_BACK, 32'd5,  F_RUN);
        add(800, I_ES | I_STEP,           V_BACK, 32'd5,  F_RUN);   // 800 steps, not yet more than limit
        add(1,   I_ES | I_STEP,           V_BACK, 32'd5,  F_RUN);   // 801st
        add(1,   I_ES,                    32'd0, 32'd10, F_RUN);    // ERR
        add(1,   I_ES | I_START,          32'd0, 32'd10, F_RUN);    // start ignored
        add(1,   I_ES | I_VZ,             32'd0, 32'd0,  F_ERR);    // IDLE, error
        add(2,   I_NONE,                  32'd0, 32'd0,  F_ERR);
        add(1,   I_ABORT,                 32'd0, 32'd0,  F_ERR);    // abort in IDLE ignored
        add(1,   I_ABORT | I_START,       32'd0, 32'd0,  F_ERR);    // start lost to abort

        // ---- abort during SLOW_SEEK ----
        add(1,   I_START,                 V_FAST, 32'd5,  F_RUN);
        add(1,   I_ES,                    32'd0, 32'd10, F_RUN);
        add(1,   I_ES | I_VZ,             V_BACK, 32'd5,  F_RUN);
        add(200, I_STEP,                  V_BACK, 32'd5,  F_RUN);
        add(1,   I_NONE,                  32'd0, 32'd5,  F_RUN);    // STOP2
        add(1,   I_VZ,                    V_SLOW, 32'd5,  F_RUN);   // SLOW_SEEK
        add(1,   I_ABORT,                 32'd0, 32'd10, F_RUN);    // ABORTING
        add(1,   I_START,                 32'd0, 32'd10, F_RUN);
        add(1,   I_VZ,                    32'd0, 32'd0,  F_ERR);    // error=1, done=0
        add(1,   I_START,                 V_FAST, 32'd5,  F_RUN);   // restart clears error

        // ---- synchronous reset in BACKOFF ----
        add(1,   I_ES,                    32'd0, 32'd10, F_RUN);
        add(1,   I_ES | I_VZ,             V_BACK, 32'd5,  F_RUN);
        add(1,   I_RST | I_ES | I_START,  32'd0, 32'd0,  F_IDLE);
        add(2,   I_NONE,                  32'd0, 32'd0,  F_IDLE);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                drive(vecs[i].in);
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_cyc%0d", i, k), outs(),
                      {vecs[i].vt, vecs[i].acc, vecs[i].fl});
            end
        end

        // ---- long seek: with no watchdog the seek never gives up ----
        @(negedge clk);
        drive(I_START);
        @(negedge clk);
        drive(I_NONE);
        repeat (10000) @(negedge clk);
        check("seek_after_10000", outs(), {V_FAST, 32'd5, F_RUN});
        drive(I_ABORT);
        @(negedge clk);
        drive(I_VZ);
        @(negedge clk);
        drive(I_NONE);
        check("abort_from_seek", outs(), {32'd0, 32'd0, F_ERR});

        // ---- closed-loop homing against a position/endstop model ----
        pos      = 500;
        zp_count = 0;
        finished = 1'b0;
        @(negedge clk);
        drive(I_START);
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            @(negedge clk);
            i_start  = 1'b0;
            i_step   = (o_v_target != 32'd0);
            if (i_step) begin
                pos = pos + (($signed(o_v_target) > 0) ? 1 : -1);
            end
            i_endstop = (pos <= 0);
            i_v_zero  = (o_v_target == 32'd0);
            @(posedge clk);
            #1;
            if (o_zero_pos) begin
                zp_count++;
            end
            if (o_done) begin
                finished = 1'b1;
            end
        end
        check("loop_finished", 69'(finished), 69'd1);
        check("loop_zero_pulses", 69'(zp_count), 69'd1);
        check("loop_final_flags", outs(), {32'd0, 32'd0, F_DONE});
        check("loop_final_pos", 69'(pos), 69'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
